sync_wconv_fifo: RTL and testbench

SYNC_WCONV_FIFO -- requirements
Module: sync_wconv_fifo

---
 rtl/sync_wconv_fifo.sv | 113 +++++++++++
 tb/tb_sync_wconv_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_wconv_fifo.sv
// sync_wconv_fifo: single-clock FIFO with independent write/read widths (power-of-two ratio).
// Define SYNC_WCONV_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module sync_wconv_fifo #(
   parameter int WR_DATA_WIDTH = 64,
   parameter int RD_DATA_WIDTH = 16,
   parameter int WR_DEPTH_WIDTH = 9,
   parameter int ALMOST_FULL_NUM = 256,
   parameter int ALMOST_EMPTY_NUM = 4,
   localparam int RD_DEPTH_WIDTH = (WR_DATA_WIDTH >= RD_DATA_WIDTH) ?
      WR_DEPTH_WIDTH + $clog2(WR_DATA_WIDTH / RD_DATA_WIDTH) :
      WR_DEPTH_WIDTH - $clog2(RD_DATA_WIDTH / WR_DATA_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WR_DATA_WIDTH-1:0]  wr_data,
   output logic                      wr_full,
   output logic                      almost_full,
   output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
   input  logic                      rd_en,
   output logic [RD_DATA_WIDTH-1:0]  rd_data,
   output logic                      rd_empty,
   output logic                      almost_empty,
   output logic [RD_DEPTH_WIDTH:0]   rd_water_level
`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
   ,
   output logic                      overflow,
   output logic                      underflow
`endif
);
   localparam bit DOWN = WR_DATA_WIDTH >= RD_DATA_WIDTH;
   localparam int MAXW = DOWN ? WR_DATA_WIDTH : RD_DATA_WIDTH;
   localparam int MINW = DOWN ? RD_DATA_WIDTH : WR_DATA_WIDTH;
   localparam int RATIO = MAXW / MINW;
   localparam int L = $clog2(RATIO);
   localparam int UA = DOWN ? WR_DEPTH_WIDTH + L : WR_DEPTH_WIDTH;
   localparam int CAP = 2 ** UA;
   localparam int WU = DOWN ? RATIO : 1;
   localparam int RU = DOWN ? 1 : RATIO;
   localparam int LW = DOWN ? L : 0;
   localparam int LR = DOWN ? 0 : L;

   if (RATIO > 16 || (1 << L) != RATIO || MAXW % MINW != 0) begin : g_bad_ratio
      $error("sync_wconv_fifo: width ratio must be a power of two from 1 to 16");
   end

   // pointers and occupancy count in narrow units; MSB is the wrap bit
   logic [UA:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, cnt_n;
   logic wa, ra;
   logic [MAXW-1:0] mem [2 ** (UA - L)];

   always_comb begin
      wa = !rst && wr_en && !wr_full;
      ra = !rst && rd_en && !rd_empty;
      wr_ptr_n = wa ? wr_ptr + (UA + 1)'(WU) : wr_ptr;
      rd_ptr_n = ra ? rd_ptr + (UA + 1)'(RU) : rd_ptr;
      cnt_n = wr_ptr_n - rd_ptr_n;
   end

   // flags and levels are registered from the post-operation count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_full <= 1'b0;
         almost_full <= 1'(ALMOST_FULL_NUM <= 0);
         wr_water_level <= '0;
         rd_empty <= 1'b1;
         almost_empty <= 1'(ALMOST_EMPTY_NUM >= 0);
         rd_water_level <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         wr_full <= cnt_n > (UA + 1)'(CAP - WU);
         almost_full <= 32'(cnt_n >> LW) >= ALMOST_FULL_NUM;
         wr_water_level <= (WR_DEPTH_WIDTH + 1)'(cnt_n >> LW);
         rd_empty <= cnt_n < (UA + 1)'(RU);
         almost_empty <= 32'(cnt_n >> LR) <= ALMOST_EMPTY_NUM;
         rd_water_level <= (RD_DEPTH_WIDTH + 1)'(cnt_n >> LR);
      end
   end

`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow <= overflow | (wr_en & wr_full);
         underflow <= underflow | (rd_en & rd_empty);
      end
   end
`endif

   // memory rows are one wide word; the narrow side selects a lane little-endian
   if (DOWN) begin : g_down
      logic [UA:0] lane;
      assign lane = rd_ptr & (UA + 1)'(RATIO - 1);
      always_ff @(posedge clk) if (wa) mem[wr_ptr[UA-1:L]] <= wr_data;
      always_ff @(posedge clk) begin
         if (rst) rd_data <= '0;
         else if (ra) rd_data <= RD_DATA_WIDTH'(mem[rd_ptr[UA-1:L]] >> (32'(lane) * RD_DATA_WIDTH));
      end
   end else begin : g_up
      always_ff @(posedge clk) begin
         if (wa) mem[wr_ptr[UA-1:L]][32'(wr_ptr[L-1:0]) * WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
      end
      always_ff @(posedge clk) begin
         if (rst) rd_data <= '0;
         else if (ra) rd_data <= mem[rd_ptr[UA-1:L]];
      end
   end
endmodule

// File: tb/tb_sync_wconv_fifo.sv
// tb_sync_wconv_fifo: scoreboard bench for sync_wconv_fifo (64->16 default, plus a 16->64 instance).
module tb_sync_wconv_fifo;
   localparam int CAP = 2048;

   logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
   logic [63:0] wr_data = '0;
   logic wr_full, almost_full, rd_empty, almost_empty;
   logic [9:0] wr_water_level;
   logic [11:0] rd_water_level;
   logic [15:0] rd_data;

   logic u_wr_en = 1'b0, u_rd_en = 1'b0;
   logic [15:0] u_wr_data = '0;
   logic u_wr_full, u_almost_full, u_rd_empty, u_almost_empty;
   logic [4:0] u_wr_level;
   logic [2:0] u_rd_level;
   logic [63:0] u_rd_data;
`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
   logic overflow, underflow, u_overflow, u_underflow;
`endif

   sync_wconv_fifo dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .almost_full(almost_full), .wr_water_level(wr_water_level), .rd_en(rd_en),
      .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
      .rd_water_level(rd_water_level)
`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   sync_wconv_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(64), .WR_DEPTH_WIDTH(4),
                     .ALMOST_FULL_NUM(8), .ALMOST_EMPTY_NUM(1)) dut_up (
      .clk(clk), .rst(rst), .wr_en(u_wr_en), .wr_data(u_wr_data), .wr_full(u_wr_full),
      .almost_full(u_almost_full), .wr_water_level(u_wr_level), .rd_en(u_rd_en),
      .rd_data(u_rd_data), .rd_empty(u_rd_empty), .almost_empty(u_almost_empty),
      .rd_water_level(u_rd_level)
`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
      , .overflow(u_overflow), .underflow(u_underflow)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0, mcnt = 0;
   bit ovf = 1'b0, unf = 1'b0, mon_on = 1'b0, m_rst, m_acc;
   logic [15:0] q[$];
   logic [15:0] exp_rd = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] wword(input int i);
      return {16'(32768 + 4 * i + 3), 16'(32768 + 4 * i + 2), 16'(32768 + 4 * i + 1), 16'(32768 + 4 * i)};
   endfunction

   // monitor: pops the scoreboard on every accepted read, checks rd_data holds otherwise
   always @(posedge clk) begin
      m_rst = rst;
      m_acc = rd_en && !rd_empty && !rst;
      #1;
      if (m_rst) begin
         exp_rd = '0;
         mon_on = 1'b1;
      end else if (m_acc) begin
         if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL rd_pop: read accepted with nothing expected, rd_data %0h", rd_data);
         end else exp_rd = q.pop_front();
      end
      if (mon_on) chk("rd_data", rd_data, exp_rd);
   end

   // one clock of stimulus; the occupancy model predicts acceptance and flags
   task automatic cyc(input logic we, input logic [63:0] wd, input logic re, input logic r = 1'b0);
      bit wa, ra;
      @(negedge clk);
      wr_en = we;
      wr_data = wd;
      rd_en = re;
      rst = r;
      @(posedge clk);
      if (r) begin
         mcnt = 0;
         q.delete();
         ovf = 1'b0;
         unf = 1'b0;
      end else begin
         wa = we && mcnt <= CAP - 4;
         ra = re && mcnt >= 1;
         if (we && !wa) ovf = 1'b1;
         if (re && !ra) unf = 1'b1;
         if (wa) for (int k = 0; k < 4; k++) q.push_back(wd[16*k +: 16]);
         mcnt = mcnt + (wa ? 4 : 0) - (ra ? 1 : 0);
      end
      #1;
      chk("wr_water_level", wr_water_level, mcnt / 4);
      chk("rd_water_level", rd_water_level, mcnt);
      chk("wr_full", wr_full, mcnt > CAP - 4);
      chk("rd_empty", rd_empty, mcnt < 1);
      chk("almost_full", almost_full, mcnt / 4 >= 256);
      chk("almost_empty", almost_empty, mcnt <= 4);
`ifdef SYNC_WCONV_FIFO_ERR_FLAG_EN
      chk("overflow", overflow, ovf);
      chk("underflow", underflow, unf);
`endif
   endtask

   initial begin
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      // single wide word split into four narrow reads, then a read on empty
      cyc(1'b1, 64'h0004_0003_0002_0001, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      // fill to capacity, then one dropped write
      for (int i = 0; i < 512; i++) cyc(1'b1, wword(i), 1'b0);
      cyc(1'b1, wword(999), 1'b0);
      // full FIFO with both requests every cycle
      for (int i = 0; i < 1000; i++) cyc(1'b1, wword(600 + i), 1'b1);
      // drain through the almost_empty boundary to empty
      for (int i = 0; i < 3000 && mcnt > 0; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      // reset mid-burst with requests active, then fresh data only
      for (int i = 0; i < 100; i++) cyc(1'b1, wword(2000 + i), i % 3 == 0);
      cyc(1'b1, wword(3000), 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, wword(3100), 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      // up-conversion: no read word until four narrow writes are stored
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         u_wr_en = 1'b1;
         u_wr_data = 16'(16'h1111 * (i + 1));
         @(posedge clk);
         #1;
         chk("up_rd_empty", u_rd_empty, i < 3);
      end
      @(negedge clk);
      u_wr_en = 1'b0;
      u_rd_en = 1'b1;
      chk("up_rd_level", u_rd_level, 1);
      @(posedge clk);
      #1;
      chk("up_rd_data", u_rd_data, 64'h4444_3333_2222_1111);
      chk("up_rd_empty_after", u_rd_empty, 1);
      @(negedge clk);
      u_rd_en = 1'b0;
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
